// File: rtl/alu_pkg.sv
// Shared widths and ALU operation encodings for the FakeCPU execute unit.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ALU_ADDU = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SUBU = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1101;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1110;

endpackage

// File: rtl/alu_div32.sv
// Combinational 32-bit divider: signed (truncating) or unsigned, with fixed
// results for a zero divisor and for the signed MIN / -1 overflow case.
module alu_div32
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              div_signed,
  output logic [DATA_W-1:0] quotient_c,
  output logic [DATA_W-1:0] remainder_c
);

  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

  logic              neg_a;
  logic              neg_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] safe_b;
  logic [DATA_W-1:0] mag_q;
  logic [DATA_W-1:0] mag_r;

  // Divide magnitudes, then restore signs: quotient by sign xor, remainder follows dividend.
  always_comb begin
    neg_a       = div_signed & dividend[DATA_W-1];
    neg_b       = div_signed & divisor[DATA_W-1];
    mag_a       = neg_a ? (~dividend + DATA_W'(1)) : dividend;
    mag_b       = neg_b ? (~divisor + DATA_W'(1)) : divisor;
    safe_b      = (divisor == '0) ? DATA_W'(1) : mag_b;
    mag_q       = mag_a / safe_b;
    mag_r       = mag_a % safe_b;
    quotient_c  = (neg_a ^ neg_b) ? (~mag_q + DATA_W'(1)) : mag_q;
    remainder_c = neg_a ? (~mag_r + DATA_W'(1)) : mag_r;

    if (divisor == '0) begin
      quotient_c  = ALL_ONES;
      remainder_c = dividend;
    end else if (div_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES)) begin
      quotient_c  = MIN_NEG;
      remainder_c = '0;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// FakeCPU execute unit: ALU result mux plus parallel divider, all outputs
// registered with a one-cycle latency from in_valid.
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic [CTRL_W-1:0]  ctrl,
  input  logic [SHAMT_W-1:0] sa,
  input  logic               div_signed,
  output logic               out_valid,
  output logic [WIDTH-1:0]   rd,
  output logic               overflow,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] alu_rd_c;
  logic             alu_ovf_c;
  logic [WIDTH-1:0] div_q_c;
  logic [WIDTH-1:0] div_r_c;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  alu_div32 u_div (
    .dividend    (rs),
    .divisor     (rt),
    .div_signed  (div_signed),
    .quotient_c  (div_q_c),
    .remainder_c (div_r_c)
  );

  // ALU operation mux; overflow only meaningful for trapping add/sub.
  always_comb begin
    sum_c     = rs + rt;
    diff_c    = rs - rt;
    alu_rd_c  = '0;
    alu_ovf_c = 1'b0;
    case (ctrl)
      ALU_ADDU: alu_rd_c = sum_c;
      ALU_ADD: begin
        alu_rd_c  = sum_c;
        alu_ovf_c = (rs[WIDTH-1] == rt[WIDTH-1]) && (sum_c[WIDTH-1] != rs[WIDTH-1]);
      end
      ALU_AND:  alu_rd_c = rs & rt;
      ALU_OR:   alu_rd_c = rs | rt;
      ALU_NOR:  alu_rd_c = ~(rs | rt);
      ALU_XOR:  alu_rd_c = rs ^ rt;
      ALU_SUBU: alu_rd_c = diff_c;
      ALU_SUB: begin
        alu_rd_c  = diff_c;
        alu_ovf_c = (rs[WIDTH-1] != rt[WIDTH-1]) && (diff_c[WIDTH-1] != rs[WIDTH-1]);
      end
      ALU_SLTU: alu_rd_c = {{(WIDTH-1){1'b0}}, (rs < rt)};
      ALU_SLT:  alu_rd_c = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
      ALU_SLL:  alu_rd_c = rt << sa;
      ALU_SRL:  alu_rd_c = rt >> sa;
      ALU_SRA:  alu_rd_c = $unsigned($signed(rt) >>> sa);
      default: begin
        alu_rd_c  = '0;
        alu_ovf_c = 1'b0;
      end
    endcase
  end

  // Capture on in_valid; otherwise hold results and drop out_valid.
  always_comb begin
    out_valid_d = 1'b0;
    rd_d        = rd_q;
    overflow_d  = overflow_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (in_valid) begin
      out_valid_d = 1'b1;
      rd_d        = alu_rd_c;
      overflow_d  = alu_ovf_c;
      quotient_d  = div_q_c;
      remainder_d = div_r_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      overflow_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
      overflow_q  <= overflow_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign overflow  = overflow_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed steps plus randomized operations checked
// against an arithmetic reference model.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [3:0]  ctrl;
  logic [4:0]  sa;
  logic        div_signed;
  logic        out_valid;
  logic [31:0] rd;
  logic        overflow;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks   = 0;
  int failures = 0;

  logic [31:0] last_rd, last_q, last_r;
  logic        last_ov;

  always #5 clk = ~clk;

  alu_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .rs         (rs),
    .rt         (rt),
    .ctrl       (ctrl),
    .sa         (sa),
    .div_signed (div_signed),
    .out_valid  (out_valid),
    .rd         (rd),
    .overflow   (overflow),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  function automatic longint sx(input logic [31:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint zx(input logic [31:0] x);
    return longint'({32'd0, x});
  endfunction

  // Reference model from plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] c, input logic [4:0] s,
                                input logic ds,
                                output logic [31:0] e_rd, output logic e_ov,
                                output logic [31:0] e_q, output logic [31:0] e_r);
    longint t;
    longint p;
    longint n;
    longint d;
    p    = longint'(1) << s;
    e_rd = 32'd0;
    e_ov = 1'b0;
    case (c)
      4'd0: e_rd = 32'(zx(a) + zx(b));
      4'd1: begin
        t    = sx(a) + sx(b);
        e_rd = 32'(t);
        e_ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd2: e_rd = a & b;
      4'd3: e_rd = a | b;
      4'd5: e_rd = ~(a | b);
      4'd6: e_rd = a ^ b;
      4'd8: e_rd = 32'(zx(a) - zx(b));
      4'd9: begin
        t    = sx(a) - sx(b);
        e_rd = 32'(t);
        e_ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd10: e_rd = (zx(a) < zx(b)) ? 32'd1 : 32'd0;
      4'd11: e_rd = (sx(a) < sx(b)) ? 32'd1 : 32'd0;
      4'd12: e_rd = 32'(zx(b) * p);
      4'd13: e_rd = 32'(zx(b) / p);
      4'd14: begin
        t = sx(b) / p;
        if (sx(b) < 0 && (sx(b) % p) != 0) t = t - 1;
        e_rd = 32'(t);
      end
      default: e_rd = 32'd0;
    endcase
    if (b == 32'd0) begin
      e_q = 32'hFFFF_FFFF;
      e_r = a;
    end else begin
      n   = ds ? sx(a) : zx(a);
      d   = ds ? sx(b) : zx(b);
      e_q = 32'(n / d);
      e_r = 32'(n % d);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                    input logic [4:0] s, input logic ds);
    logic [31:0] e_rd, e_q, e_r;
    logic        e_ov;
    rs = a; rt = b; ctrl = c; sa = s; div_signed = ds; in_valid = 1'b1;
    model(a, b, c, s, ds, e_rd, e_ov, e_q, e_r);
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("rd", rd, e_rd);
    chk("overflow", 32'(overflow), 32'(e_ov));
    chk("quotient", quotient, e_q);
    chk("remainder", remainder, e_r);
    last_rd = e_rd; last_ov = e_ov; last_q = e_q; last_r = e_r;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    rs = $urandom; rt = $urandom; ctrl = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("hold_rd", rd, last_rd);
    chk("hold_ov", 32'(overflow), 32'(last_ov));
    chk("hold_q", quotient, last_q);
    chk("hold_r", remainder, last_r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rd"}, rd, 32'd0);
    chk({tag, "_ov"}, 32'(overflow), 32'd0);
    chk({tag, "_q"}, quotient, 32'd0);
    chk({tag, "_r"}, remainder, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int unsigned sel;

    // Reset beats in_valid.
    rst_n = 1'b0; in_valid = 1'b1; rs = 32'd5; rt = 32'd3; ctrl = 4'd0; sa = 5'd0;
    div_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    last_rd = 32'd0; last_ov = 1'b0; last_q = 32'd0; last_r = 32'd0;

    op(32'h7FFF_FFFF, 32'd1, 4'b0001, 5'd0, 1'b0);
    chk("add_ovf_rd", rd, 32'h8000_0000);
    chk("add_ovf_flag", 32'(overflow), 32'd1);
    op(32'h7FFF_FFFF, 32'd1, 4'b0000, 5'd0, 1'b0);
    chk("addu_no_ovf", 32'(overflow), 32'd0);
    op(32'h8000_0000, 32'd1, 4'b1001, 5'd0, 1'b0);
    chk("sub_ovf_rd", rd, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", 32'(overflow), 32'd1);
    op(32'hFFFF_FFFF, 32'd1, 4'b1011, 5'd0, 1'b0);
    chk("slt", rd, 32'd1);
    op(32'hFFFF_FFFF, 32'd1, 4'b1010, 5'd0, 1'b0);
    chk("sltu", rd, 32'd0);
    op(32'd0, 32'h8000_0010, 4'b1100, 5'd4, 1'b0);
    chk("sll", rd, 32'h0000_0100);
    op(32'd0, 32'h8000_0010, 4'b1101, 5'd4, 1'b0);
    chk("srl", rd, 32'h0800_0001);
    op(32'd0, 32'h8000_0010, 4'b1110, 5'd4, 1'b0);
    chk("sra", rd, 32'hF800_0001);
    op(32'd0, 32'd0, 4'b0101, 5'd0, 1'b0);
    chk("nor", rd, 32'hFFFF_FFFF);
    op(32'hFFFF_FFF9, 32'd2, 4'b0000, 5'd0, 1'b1);
    chk("sdiv_q", quotient, 32'hFFFF_FFFD);
    chk("sdiv_r", remainder, 32'hFFFF_FFFF);
    op(32'hFFFF_FFF9, 32'd2, 4'b0000, 5'd0, 1'b0);
    chk("udiv_q", quotient, 32'h7FFF_FFFC);
    chk("udiv_r", remainder, 32'd1);
    op(32'd5, 32'd0, 4'b0000, 5'd0, 1'b1);
    chk("div0_q", quotient, 32'hFFFF_FFFF);
    chk("div0_r", remainder, 32'd5);
    op(32'h8000_0000, 32'hFFFF_FFFF, 4'b0000, 5'd0, 1'b1);
    chk("sdiv_ovf_q", quotient, 32'h8000_0000);
    chk("sdiv_ovf_r", remainder, 32'd0);
    op(32'h1234_5678, 32'h0F0F_0F0F, 4'b0100, 5'd0, 1'b0);
    chk("unused_ctrl", rd, 32'd0);

    // Back-to-back, then hold.
    op(32'd10, 32'd20, 4'b0000, 5'd0, 1'b0);
    op(32'd100, 32'd7, 4'b1000, 5'd0, 1'b0);
    op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0110, 5'd0, 1'b0);
    idle();
    idle();

    // Operation in flight is discarded by reset.
    op(32'd9, 32'd4, 4'b0000, 5'd0, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_zero("midreset");
    rst_n = 1'b1;
    last_rd = 32'd0; last_ov = 1'b0; last_q = 32'd0; last_r = 32'd0;
    idle();

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      if (sel == 9) idle();
      else op(a, b, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
